// File: rtl/hps_sd_pkg.sv
// Shared definitions for the HPS virtual-disk sector bridge.
//   SECTOR_WORDS : 16-bit words per 512-byte sector
//   ERR_*        : blk_err encodings reported with blk_done
//   state_t      : bridge FSM states
package hps_sd_pkg;

  localparam int SECTOR_WORDS = 256;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_RO      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sector_dpram.sv
// 256x16 true dual-port sector buffer with registered read outputs.
//   clk, rst             : clock, async active-high reset (output registers only)
//   a_addr/a_wdata/a_we  : port A (HPS side), a_rdata one cycle after a_addr
//   b_addr/b_wdata/b_we  : port B (core side), b_rdata one cycle after b_addr
// When both ports write the same word in the same cycle, port A wins.
module sector_dpram
  import hps_sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a_addr,
  input  logic [15:0] a_wdata,
  input  logic        a_we,
  output logic [15:0] a_rdata,
  input  logic [7:0]  b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_we,
  output logic [15:0] b_rdata
);

  logic [15:0] mem [SECTOR_WORDS];

  // Storage has no reset; contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (b_we && !(a_we && (a_addr == b_addr)))
      mem[b_addr] <= b_wdata;
    if (a_we)
      mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/hps_sd_sector_bridge.sv
// Per-drive bridge between the core's single-sector block requests and the
// HPS virtual-disk handshake. Owns the sector buffer, tracks mount state and
// rejects out-of-range / no-media / read-only requests locally.
//   clk_sys, reset              : clock, async active-high reset
//   img_mounted/readonly/size   : mount notification from HPS
//   sd_lba/sd_rd/sd_wr/sd_ack   : HPS request handshake
//   sd_buff_addr/dout/wr/din    : HPS side of the sector buffer
//   blk_lba/rd/wr/busy/done/err : core request interface
//   buf_addr/wdata/we/rdata     : core side of the sector buffer
//   mounted, capacity           : image present, size in sectors
module hps_sd_sector_bridge
  import hps_sd_pkg::*;
#(
  parameter int TIMEOUT     = 50000000,
  parameter bit ALLOW_WRITE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  input  logic [31:0] blk_lba,
  input  logic        blk_rd,
  input  logic        blk_wr,
  output logic        blk_busy,
  output logic        blk_done,
  output logic [1:0]  blk_err,
  input  logic [7:0]  buf_addr,
  input  logic [15:0] buf_wdata,
  input  logic        buf_we,
  output logic [15:0] buf_rdata,
  output logic        mounted,
  output logic [31:0] capacity
);

  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] lba_nxt;
  logic        rd_nxt, wr_nxt;
  logic        op_wr, op_wr_nxt;
  logic [1:0]  err_nxt;
  logic [31:0] timer, timer_nxt;
  logic        ro;

  // Mount tracking runs independently of the FSM so a (re)mount during a
  // transfer updates geometry without aborting it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mounted  <= 1'b0;
      capacity <= '0;
      ro       <= 1'b0;
    end else if (img_mounted) begin
      capacity <= img_size[40:9];
      mounted  <= (img_size != 64'd0);
      ro       <= img_readonly | ~ALLOW_WRITE;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      op_wr   <= 1'b0;
      blk_err <= ERR_OK;
      timer   <= '0;
    end else begin
      state   <= state_nxt;
      sd_lba  <= lba_nxt;
      sd_rd   <= rd_nxt;
      sd_wr   <= wr_nxt;
      op_wr   <= op_wr_nxt;
      blk_err <= err_nxt;
      timer   <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lba_nxt   = sd_lba;
    rd_nxt    = sd_rd;
    wr_nxt    = sd_wr;
    op_wr_nxt = op_wr;
    err_nxt   = blk_err;
    timer_nxt = timer;
    case (state)
      ST_IDLE: begin
        if (blk_rd || blk_wr) begin
          lba_nxt   = blk_lba;
          op_wr_nxt = ~blk_rd;   // read wins when both are raised
          err_nxt   = ERR_OK;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!mounted || (sd_lba >= capacity)) begin
          err_nxt   = ERR_RANGE;
          state_nxt = ST_DONE;
        end else if (op_wr && ro) begin
          err_nxt   = ERR_RO;
          state_nxt = ST_DONE;
        end else begin
          rd_nxt    = ~op_wr;
          wr_nxt    = op_wr;
          timer_nxt = '0;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack already high on entry is taken on the first REQ cycle.
        if (sd_ack) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = ST_XFER;
        end else if (timer == TIMEOUT_M1) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = ST_DONE;
        end else begin
          timer_nxt = timer + 32'd1;
        end
      end
      ST_XFER: begin
        if (!sd_ack) begin
          err_nxt   = ERR_OK;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign blk_busy = (state != ST_IDLE);
  assign blk_done = (state == ST_DONE);

  sector_dpram u_buf (
    .clk     (clk_sys),
    .rst     (reset),
    .a_addr  (sd_buff_addr),
    .a_wdata (sd_buff_dout),
    .a_we    (sd_buff_wr),
    .a_rdata (sd_buff_din),
    .b_addr  (buf_addr),
    .b_wdata (buf_wdata),
    .b_we    (buf_we),
    .b_rdata (buf_rdata)
  );

endmodule

// File: tb/tb_hps_sd_sector_bridge.sv
module tb_hps_sd_sector_bridge;
  import hps_sd_pkg::*;

  localparam int TMO = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        img_mounted = 1'b0, img_readonly = 1'b0;
  logic [63:0] img_size = '0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_addr = '0;
  logic [15:0] sd_buff_dout = '0;
  logic        sd_buff_wr = 1'b0;
  logic [15:0] sd_buff_din;
  logic [31:0] blk_lba = '0;
  logic        blk_rd = 1'b0, blk_wr = 1'b0;
  logic        blk_busy, blk_done;
  logic [1:0]  blk_err;
  logic [7:0]  buf_addr = '0;
  logic [15:0] buf_wdata = '0;
  logic        buf_we = 1'b0;
  logic [15:0] buf_rdata;
  logic        mounted;
  logic [31:0] capacity;

  // second instance: read-only drive (CDROM style)
  logic        blk_rd2 = 1'b0, blk_wr2 = 1'b0;
  logic [31:0] d2_sd_lba, d2_capacity;
  logic        d2_sd_rd, d2_sd_wr, d2_busy, d2_done, d2_mounted;
  logic [1:0]  d2_err;
  logic [15:0] d2_sd_buff_din, d2_buf_rdata;

  always #5 clk_sys = ~clk_sys;

  hps_sd_sector_bridge #(.TIMEOUT(TMO), .ALLOW_WRITE(1'b1)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .blk_lba(blk_lba), .blk_rd(blk_rd), .blk_wr(blk_wr),
    .blk_busy(blk_busy), .blk_done(blk_done), .blk_err(blk_err),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we),
    .buf_rdata(buf_rdata), .mounted(mounted), .capacity(capacity)
  );

  hps_sd_sector_bridge #(.TIMEOUT(TMO), .ALLOW_WRITE(1'b0)) dut_ro (
    .clk_sys(clk_sys), .reset(reset),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .sd_lba(d2_sd_lba), .sd_rd(d2_sd_rd), .sd_wr(d2_sd_wr), .sd_ack(1'b0),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(1'b0), .sd_buff_din(d2_sd_buff_din),
    .blk_lba(blk_lba), .blk_rd(blk_rd2), .blk_wr(blk_wr2),
    .blk_busy(d2_busy), .blk_done(d2_done), .blk_err(d2_err),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(1'b0),
    .buf_rdata(d2_buf_rdata), .mounted(d2_mounted), .capacity(d2_capacity)
  );

  // reference model: sector buffer contents and mount geometry
  logic [15:0] ref_mem [256];
  logic        ref_mounted = 1'b0, ref_ro = 1'b0;
  logic [31:0] ref_cap = '0;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic mount(input logic [63:0] size, input logic rdonly);
    img_size = size; img_readonly = rdonly; img_mounted = 1'b1;
    step();
    img_mounted = 1'b0;
    ref_cap     = 32'(size / 512);
    ref_mounted = (size != 0);
    ref_ro      = rdonly;
    chk("mounted", {63'd0, mounted}, {63'd0, ref_mounted});
    chk("capacity", {32'd0, capacity}, {32'd0, ref_cap});
  endtask

  task automatic core_fill(input bit rnd, input logic [15:0] v);
    for (int i = 0; i < 256; i++) begin
      buf_addr  = 8'(i);
      buf_wdata = rnd ? 16'($urandom) : v;
      buf_we    = 1'b1;
      ref_mem[i] = buf_wdata;
      step();
    end
    buf_we = 1'b0;
  endtask

  task automatic core_rd(input logic [7:0] a);
    buf_addr = a;
    step();
    chk("buf_rdata", {48'd0, buf_rdata}, {48'd0, ref_mem[a]});
  endtask

  // One core request with the HPS acting as a well-behaved (or mute) host.
  task automatic do_req(input bit wr, input logic [31:0] lba, input int ack_dly,
                        input bit no_ack, input bit idx_data);
    logic [1:0] exp;
    int hi, w, exp_hi;
    if (!ref_mounted || lba >= ref_cap) exp = ERR_RANGE;
    else if (wr && ref_ro)              exp = ERR_RO;
    else if (no_ack)                    exp = ERR_TIMEOUT;
    else                                exp = ERR_OK;
    blk_lba = lba; blk_rd = !wr; blk_wr = wr;
    if (!no_ack && ack_dly == 0 && exp == ERR_OK) sd_ack = 1'b1;
    step();
    blk_rd = 1'b0; blk_wr = 1'b0;
    chk("busy_after_req", {63'd0, blk_busy}, 64'd1);
    step();
    if (exp == ERR_RANGE || exp == ERR_RO) begin
      chk("rej_done", {63'd0, blk_done}, 64'd1);
      chk("rej_err", {62'd0, blk_err}, {62'd0, exp});
      chk("rej_noreq", {62'd0, sd_wr, sd_rd}, 64'd0);
      step();
      chk("rej_idle", {63'd0, blk_busy}, 64'd0);
      chk("err_hold", {62'd0, blk_err}, {62'd0, exp});
      return;
    end
    chk("sd_lba", {32'd0, sd_lba}, {32'd0, lba});
    chk("req_dir", {62'd0, sd_wr, sd_rd}, wr ? 64'd2 : 64'd1);
    hi = 1;
    while ((sd_rd || sd_wr) && hi <= TMO + 4) begin
      if (!no_ack && hi >= ack_dly) sd_ack = 1'b1;
      step();
      if (sd_rd || sd_wr) hi++;
    end
    exp_hi = no_ack ? TMO : (ack_dly < 1 ? 1 : ack_dly);
    chk("req_cycles", 64'(hi), 64'(exp_hi));
    if (no_ack) begin
      chk("tmo_done", {63'd0, blk_done}, 64'd1);
      chk("tmo_err", {62'd0, blk_err}, {62'd0, ERR_TIMEOUT});
      step();
      chk("tmo_idle", {63'd0, blk_busy}, 64'd0);
      return;
    end
    chk("xfer_busy", {63'd0, blk_busy & ~blk_done}, 64'd1);
    for (int i = 0; i < 256; i++) begin
      sd_buff_addr = 8'(i);
      if (!wr) begin
        sd_buff_dout = idx_data ? 16'(i) : 16'($urandom);
        sd_buff_wr   = 1'b1;
        ref_mem[i]   = sd_buff_dout;
        step();
      end else begin
        step();
        chk("sd_buff_din", {48'd0, sd_buff_din}, {48'd0, ref_mem[i]});
      end
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    w = 0;
    while (!blk_done && w < 3) begin
      step();
      w++;
    end
    chk("done_seen", {63'd0, blk_done}, 64'd1);
    chk("ok_err", {62'd0, blk_err}, {62'd0, ERR_OK});
    step();
    chk("ok_idle", {63'd0, blk_busy}, 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sd_lba"}, {32'd0, sd_lba}, 64'd0);
    chk({tag, "_sd_rdwr"}, {62'd0, sd_wr, sd_rd}, 64'd0);
    chk({tag, "_sd_buff_din"}, {48'd0, sd_buff_din}, 64'd0);
    chk({tag, "_busy_done"}, {62'd0, blk_busy, blk_done}, 64'd0);
    chk({tag, "_err"}, {62'd0, blk_err}, 64'd0);
    chk({tag, "_buf_rdata"}, {48'd0, buf_rdata}, 64'd0);
    chk({tag, "_mounted"}, {63'd0, mounted}, 64'd0);
    chk({tag, "_capacity"}, {32'd0, capacity}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // read with index pattern, ack after 10 request cycles
    mount(64'h100000, 1'b0);
    do_req(1'b0, 32'd5, 10, 1'b0, 1'b1);
    core_rd(8'h7F);
    chk("rd_7f_const", {48'd0, buf_rdata}, 64'h007F);

    // write last legal sector from a constant core fill
    core_fill(1'b0, 16'hA5A5);
    do_req(1'b1, 32'd2047, 3, 1'b0, 1'b0);

    // just past the end
    do_req(1'b0, 32'd2048, 4, 1'b0, 1'b0);

    // same-address write collision: HPS side wins
    sd_buff_addr = 8'h33; sd_buff_dout = 16'h1234; sd_buff_wr = 1'b1;
    buf_addr = 8'h33; buf_wdata = 16'hBEEF; buf_we = 1'b1;
    step();
    sd_buff_wr = 1'b0; buf_we = 1'b0;
    ref_mem[8'h33] = 16'h1234;
    core_rd(8'h33);

    // randomized traffic, including ack already high on REQ entry
    for (int n = 0; n < 8; n++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      if (wr && $urandom_range(0, 1) == 1) core_fill(1'b1, 16'h0);
      do_req(wr, 32'($urandom_range(0, 2100)), $urandom_range(0, 12), 1'b0, 1'b0);
      if (!wr) begin
        core_rd(8'($urandom));
        core_rd(8'($urandom));
      end
    end

    // read-only image
    mount(64'h80000, 1'b1);
    do_req(1'b1, 32'd0, 2, 1'b0, 1'b0);
    do_req(1'b0, 32'd0, 2, 1'b0, 1'b0);

    // write-disabled instance with a writable image
    mount(64'h80000, 1'b0);
    blk_lba = 32'd0; blk_wr2 = 1'b1;
    step();
    blk_wr2 = 1'b0;
    step();
    chk("ro_inst_done", {63'd0, d2_done}, 64'd1);
    chk("ro_inst_err", {62'd0, d2_err}, {62'd0, ERR_RO});
    chk("ro_inst_nowr", {63'd0, d2_sd_wr}, 64'd0);
    step();

    // host never acks, then a normal request recovers
    do_req(1'b0, 32'd9, 0, 1'b1, 1'b0);
    do_req(1'b0, 32'd10, 5, 1'b0, 1'b0);

    // ejected image
    mount(64'd0, 1'b0);
    do_req(1'b0, 32'd0, 1, 1'b0, 1'b0);

    // reset in the middle of a transfer
    mount(64'h100000, 1'b0);
    buf_addr = 8'h05;
    blk_lba = 32'd7; blk_rd = 1'b1;
    step();
    blk_rd = 1'b0;
    step();
    sd_ack = 1'b1;
    step();
    chk("pre_rst_xfer", {63'd0, blk_busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    sd_ack = 1'b0;
    step();
    reset = 1'b0;
    ref_mounted = 1'b0; ref_cap = '0;
    step();
    chk("post_rst_mounted", {63'd0, mounted}, 64'd0);
    do_req(1'b0, 32'd0, 1, 1'b0, 1'b0);
    mount(64'h100000, 1'b0);
    do_req(1'b0, 32'd1, 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
